key_step_gen: RTL and testbench

- Upstream stage of the LED running-light FSM.
- Debounces two active-low board keys: K_RUN toggles run/pause, K_SPD cycles the step speed.
- Generates the one-cycle step pulse that drives the state counter's advance condition (replaces the fixed 1 s tick).
- Also exports the run flag and speed code for status display.

---
 rtl/key_step_gen_pkg.sv | 30 +++
 rtl/key_step_gen_debounce.sv | 78 +++++++
 rtl/key_step_gen.sv | 74 +++++++
 tb/tb_key_step_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_step_gen_pkg.sv
// Shared types and constants for the key-driven step generator.
// Debounce state encodings, speed codes and default timing parameters.
package key_step_gen_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam logic [1:0] SPD_1HZ = 2'd0;
    localparam logic [1:0] SPD_2HZ = 2'd1;
    localparam logic [1:0] SPD_4HZ = 2'd2;
    localparam logic [1:0] SPD_8HZ = 2'd3;

`ifdef SIMULATION
    localparam int unsigned SYS_FREQ_DEF        = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
`else
    localparam int unsigned SYS_FREQ_DEF        = 12_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 240_000;
`endif

    // Each speed step halves the period: 1 s, 0.5 s, 0.25 s, 0.125 s.
    function automatic logic [31:0] step_period(input logic [31:0] base, input logic [1:0] spd);
        return base >> spd;
    endfunction

endpackage

// File: rtl/key_step_gen_debounce.sv
// Synchronises and debounces one active-low key; emits a one-cycle press pulse.
// Latency: raw falling edge to press pulse is DEBOUNCE_CYCLES+3 cycles.
// No backpressure: the pulse is fire-and-forget, one per accepted press.
module key_debounce
    import key_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic iclk,
    input  logic irst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;

    always_ff @(posedge iclk) begin
        if (irst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            state   <= RELEASED;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press   <= press_nxt;
        end
    end

    // The RELEASED->PRESS_WAIT cycle already saw one low sample, so the
    // wait state needs DEBOUNCE_CYCLES more before committing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        press_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync_q2) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (sync_q2) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_q2) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!sync_q2) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

endmodule

// File: rtl/key_step_gen.sv
// Run/pause and speed control from two debounced keys; generates the step pulse.
// Latency: step registered at terminal count; key effects one cycle after press pulse.
// No backpressure: step is a one-cycle strobe to the state counter.
module key_step_gen
    import key_step_gen_pkg::*;
#(
    parameter int unsigned SYS_FREQ        = SYS_FREQ_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       ikey_run_n,
    input  logic       ikey_spd_n,
    output logic       owstep,
    output logic       owrun,
    output logic [1:0] owvspeed
);

    logic        run_press;
    logic        spd_press;
    logic [31:0] step_cnt;
    logic [31:0] period;
    logic        term;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .iclk  (iclk),
        .irst  (irst),
        .key_n (ikey_run_n),
        .press (run_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_spd (
        .iclk  (iclk),
        .irst  (irst),
        .key_n (ikey_spd_n),
        .press (spd_press)
    );

    assign period = step_period(32'(SYS_FREQ), owvspeed);
    assign term   = (step_cnt == period - 32'd1);

    always_ff @(posedge iclk) begin
        if (irst) begin
            owrun    <= 1'b1;
            owvspeed <= SPD_1HZ;
        end else begin
            if (run_press) owrun    <= ~owrun;
            if (spd_press) owvspeed <= owvspeed + 2'd1;
        end
    end

    // A speed change restarts the period; pausing on terminal count holds
    // the counter at P-1 so the step fires on the first resumed cycle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            step_cnt <= '0;
            owstep   <= 1'b0;
        end else if (spd_press) begin
            step_cnt <= '0;
            owstep   <= 1'b0;
        end else if (owrun && !run_press) begin
            if (term) begin
                step_cnt <= '0;
                owstep   <= 1'b1;
            end else begin
                step_cnt <= step_cnt + 32'd1;
                owstep   <= 1'b0;
            end
        end else begin
            owstep <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen with SYS_FREQ=16, DEBOUNCE_CYCLES=4.
// Samples 1 time unit after each rising edge; expectations are hand-computed.
module tb_key_step_gen;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic       ikey_run_n = 1'b1;
    logic       ikey_spd_n = 1'b1;
    logic       owstep;
    logic       owrun;
    logic [1:0] owvspeed;

    int total = 0;
    int bad   = 0;

    key_step_gen #(.SYS_FREQ(16), .DEBOUNCE_CYCLES(4)) dut (
        .iclk       (iclk),
        .irst       (irst),
        .ikey_run_n (ikey_run_n),
        .ikey_spd_n (ikey_spd_n),
        .owstep     (owstep),
        .owrun      (owrun),
        .owvspeed   (owvspeed)
    );

    always #5 iclk = ~iclk;

    task automatic step(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until the next step pulse, bounded so a dead counter still ends.
    task automatic wait_step(input string tag, input int exp);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (owstep !== 1'b1 && n < 200);
        chk(tag, n, exp);
    endtask

    task automatic press_spd(input logic [1:0] exp_spd, input int per);
        ikey_spd_n = 1'b0;
        step(8);
        chk("spd_code", {30'd0, owvspeed}, {30'd0, exp_spd});
        chk("spd_clear_nostep", {31'd0, owstep}, 32'd0);
        wait_step("spd_period", per);
        ikey_spd_n = 1'b1;
        step(10);
    endtask

    initial begin
        int seen;

        step(3);
        chk("rst_step", {31'd0, owstep}, 32'd0);
        chk("rst_run", {31'd0, owrun}, 32'd1);
        chk("rst_spd", {30'd0, owvspeed}, 32'd0);
        irst = 1'b0;

        wait_step("first_step", 16);
        wait_step("step2", 16);
        wait_step("step3", 16);
        chk("idle_run", {31'd0, owrun}, 32'd1);

        // Speed key held 20 cycles: one increment, 8 edges after the drive.
        ikey_spd_n = 1'b0;
        step(1);
        chk("step_one_cycle", {31'd0, owstep}, 32'd0);
        step(6);
        chk("spd_before", {30'd0, owvspeed}, 32'd0);
        step(1);
        chk("spd_after", {30'd0, owvspeed}, 32'd1);
        chk("spd_nostep", {31'd0, owstep}, 32'd0);
        wait_step("spd1_first", 8);
        step(4);
        ikey_spd_n = 1'b1;
        wait_step("spd1_held", 4);
        wait_step("spd1_period", 8);
        chk("spd_single", {30'd0, owvspeed}, 32'd1);

        // Run key glitches then settles low.
        ikey_run_n = 1'b0; step(1);
        ikey_run_n = 1'b1; step(1);
        ikey_run_n = 1'b0; step(1);
        ikey_run_n = 1'b1; step(1);
        ikey_run_n = 1'b0;
        step(4);
        chk("bounce_step", {31'd0, owstep}, 32'd1);
        step(3);
        chk("bounce_run_hold", {31'd0, owrun}, 32'd1);
        step(1);
        chk("pause", {31'd0, owrun}, 32'd0);
        chk("pause_nostep", {31'd0, owstep}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (owstep === 1'b1) seen++;
        end
        chk("paused_steps", seen, 0);
        ikey_run_n = 1'b1;
        step(12);
        chk("release_no_toggle", {31'd0, owrun}, 32'd0);
        ikey_run_n = 1'b0;
        step(8);
        chk("resume", {31'd0, owrun}, 32'd1);
        chk("resume_nostep", {31'd0, owstep}, 32'd0);
        wait_step("resume_remaining", 5);
        ikey_run_n = 1'b1;
        step(10);

        press_spd(2'd2, 4);
        press_spd(2'd3, 2);
        press_spd(2'd0, 16);
        press_spd(2'd1, 8);

        // Both keys on the same cycle.
        ikey_run_n = 1'b0;
        ikey_spd_n = 1'b0;
        step(7);
        chk("both_run_before", {31'd0, owrun}, 32'd1);
        chk("both_spd_before", {30'd0, owvspeed}, 32'd1);
        step(1);
        chk("both_run", {31'd0, owrun}, 32'd0);
        chk("both_spd", {30'd0, owvspeed}, 32'd2);
        chk("both_nostep", {31'd0, owstep}, 32'd0);
        ikey_run_n = 1'b1;
        ikey_spd_n = 1'b1;
        step(10);
        ikey_run_n = 1'b0;
        step(8);
        chk("both_resume", {31'd0, owrun}, 32'd1);
        wait_step("both_cleared", 4);

        // Speed press lands on terminal count (8 edges after a step at P=4).
        ikey_run_n = 1'b1;
        ikey_spd_n = 1'b0;
        step(8);
        chk("term_spd", {30'd0, owvspeed}, 32'd3);
        chk("term_spd_nostep", {31'd0, owstep}, 32'd0);
        wait_step("term_spd_next", 2);
        ikey_spd_n = 1'b1;
        step(10);
        chk("align_step", {31'd0, owstep}, 32'd1);

        // Pause lands on terminal count (P=2).
        ikey_run_n = 1'b0;
        step(8);
        chk("term_pause", {31'd0, owrun}, 32'd0);
        chk("term_pause_nostep", {31'd0, owstep}, 32'd0);
        ikey_run_n = 1'b1;
        step(10);
        ikey_run_n = 1'b0;
        step(8);
        chk("term_resume", {31'd0, owrun}, 32'd1);
        wait_step("term_resume_step", 1);
        ikey_run_n = 1'b1;
        step(10);

        // Reset while the speed key sits in PRESS_WAIT, key kept held.
        ikey_spd_n = 1'b0;
        step(4);
        irst = 1'b1;
        step(1);
        chk("rstA_run", {31'd0, owrun}, 32'd1);
        chk("rstA_spd", {30'd0, owvspeed}, 32'd0);
        chk("rstA_step", {31'd0, owstep}, 32'd0);
        step(1);
        irst = 1'b0;
        step(7);
        chk("rstA_held_before", {30'd0, owvspeed}, 32'd0);
        step(1);
        chk("rstA_held_after", {30'd0, owvspeed}, 32'd1);
        ikey_spd_n = 1'b1;
        step(10);

        // Reset while paused at speed 2, run key kept held.
        press_spd(2'd2, 4);
        ikey_run_n = 1'b0;
        step(8);
        chk("rstB_paused", {31'd0, owrun}, 32'd0);
        irst = 1'b1;
        step(1);
        chk("rstB_run", {31'd0, owrun}, 32'd1);
        chk("rstB_spd", {30'd0, owvspeed}, 32'd0);
        chk("rstB_step", {31'd0, owstep}, 32'd0);
        irst = 1'b0;
        step(7);
        chk("rstB_held_before", {31'd0, owrun}, 32'd1);
        step(1);
        chk("rstB_held_after", {31'd0, owrun}, 32'd0);
        ikey_run_n = 1'b1;
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
